// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues word fetches
// under a credit limit, buffers in-order responses in a prefetch queue and
// applies branch redirects from decode, with optional MIPS delay-slot timing.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned           QDEPTH     = 4,
  parameter bit                    DELAY_SLOT = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req_out,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic                  imem_ready_in,
  input  logic                  imem_rvalid_in,
  input  logic [31:0]           imem_rdata_in,
  output logic [31:0]           ins_out,
  output logic [ADDR_WIDTH-1:0] ins_pc_out,
  output logic [ADDR_WIDTH-1:0] ins_pcn_out,
  output logic                  ins_valid_out,
  input  logic                  ins_ready_in,
  input  logic                  redirect_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic                  flushing_out
);

  localparam int unsigned           PW         = $clog2(QDEPTH);
  localparam int unsigned           CW         = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);

  typedef enum logic {RUN, ARMED} state_t;

  state_t                state_q;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_WIDTH-1:0] target_q;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         disc_q, disc_d;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [31:0]           ins_mem_q [QDEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q  [QDEPTH];

  logic                  issue, pop, resp, push, flush;
  logic [CW:0]           credit;
  logic [ADDR_WIDTH-1:0] redir_pc, flush_pc, head_pc;

  assign ins_valid_out = (count_q != '0);
  assign head_pc       = pc_mem_q[rd_ptr_q];
  assign ins_out       = ins_valid_out ? ins_mem_q[rd_ptr_q] : '0;
  assign ins_pc_out    = ins_valid_out ? head_pc : '0;
  assign ins_pcn_out   = ins_valid_out ? head_pc + WORD_STEP : '0;
  assign imem_addr_out = fetch_pc_q;
  assign flushing_out  = (disc_q != '0);

  // Issue/response/pop handshakes, flush decision and next-state counters
  always_comb begin
    credit       = {1'b0, count_q} + {1'b0, outst_q};
    imem_req_out = run_q && (credit < (CW+1)'(QDEPTH));
    issue        = imem_req_out && imem_ready_in;
    pop          = ins_valid_out && ins_ready_in;
    resp         = imem_rvalid_in && (outst_q != '0);
    push         = resp && (disc_q == '0);
    flush        = pop && ((state_q == ARMED) ||
                           ((state_q == RUN) && (DELAY_SLOT == 1'b0) && redirect_in));
    redir_pc     = redirect_pc_in & ALIGN_MASK;
    flush_pc     = (state_q == ARMED) ? target_q : redir_pc;

    outst_d = outst_q + CW'(issue) - CW'(resp);

    // Responses are in order, so one running PC stands in for a per-request
    // PC FIFO: discarded words never advance it and a flush reloads it.
    disc_d    = disc_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    fetch_pc_d = issue ? fetch_pc_q + WORD_STEP : fetch_pc_q;
    resp_pc_d  = push  ? resp_pc_q + WORD_STEP  : resp_pc_q;
    if (resp && (disc_q != '0)) disc_d = disc_q - CW'(1);
    if (flush) begin
      disc_d     = outst_d;
      count_d    = '0;
      fetch_pc_d = flush_pc;
      resp_pc_d  = flush_pc;
    end
  end

  // Control state: PC, counters, queue pointers and redirect FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      target_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (state_q == RUN) begin
        if (pop && redirect_in && DELAY_SLOT) begin
          state_q  <= ARMED;
          target_q <= redir_pc;
        end
      end else if (pop) begin
        state_q <= RUN;
      end
    end
  end

  // Queue storage: pure datapath, contents are qualified by count_q
  always_ff @(posedge clock) begin
    if (push) begin
      ins_mem_q[wr_ptr_q] <= imem_rdata_in;
      pc_mem_q[wr_ptr_q]  <= resp_pc_q;
    end
  end

  // A response with nothing outstanding is a memory-side protocol error
  a_no_orphan_resp: assert property (@(posedge clock) disable iff (reset)
                                     imem_rvalid_in |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for two fetch_unit instances (32-bit with
// delay slot, 16-bit without) against latency-programmable memory models
// and an expected-PC scoreboard per instance.
module tb_fetch_unit;

  localparam logic [31:0] NONE32 = 32'hFFFF_FFFF;

  logic        clock;
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        a_rst, a_req, a_ready, a_rvalid, a_valid, a_ins_rdy, a_redir, a_flushing;
  logic [31:0] a_addr, a_rdata, a_ins, a_pc, a_pcn, a_rpc;

  logic        b_rst, b_req, b_ready, b_rvalid, b_valid, b_ins_rdy, b_redir, b_flushing;
  logic [15:0] b_addr, b_pc, b_pcn, b_rpc;
  logic [31:0] b_rdata, b_ins;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0040_0000), .QDEPTH(4), .DELAY_SLOT(1'b1)) u_ds (
    .clock(clock), .reset(a_rst),
    .imem_req_out(a_req), .imem_addr_out(a_addr), .imem_ready_in(a_ready),
    .imem_rvalid_in(a_rvalid), .imem_rdata_in(a_rdata),
    .ins_out(a_ins), .ins_pc_out(a_pc), .ins_pcn_out(a_pcn), .ins_valid_out(a_valid),
    .ins_ready_in(a_ins_rdy), .redirect_in(a_redir), .redirect_pc_in(a_rpc),
    .flushing_out(a_flushing));

  fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'hFFF0), .QDEPTH(4), .DELAY_SLOT(1'b0)) u_nd (
    .clock(clock), .reset(b_rst),
    .imem_req_out(b_req), .imem_addr_out(b_addr), .imem_ready_in(b_ready),
    .imem_rvalid_in(b_rvalid), .imem_rdata_in(b_rdata),
    .ins_out(b_ins), .ins_pc_out(b_pc), .ins_pcn_out(b_pcn), .ins_valid_out(b_valid),
    .ins_ready_in(b_ins_rdy), .redirect_in(b_redir), .redirect_pc_in(b_rpc),
    .flushing_out(b_flushing));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model A ----------------
  int unsigned a_lat = 1;
  bit          a_rnd = 1'b0;
  logic [31:0] a_pq[$];
  int unsigned a_dq[$];
  int unsigned a_issues = 0;
  bit          a_seen_iss = 1'b0;
  bit          a_seen_rv  = 1'b0;
  logic [31:0] a_first_addr = '0;
  int unsigned a_first_rv = 0;

  initial begin
    a_ready = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
    forever begin
      @(negedge clock);
      a_rvalid = 1'b0;
      if (a_rst) begin
        a_pq.delete(); a_dq.delete(); a_ready = 1'b0;
      end else begin
        if (a_dq.size() != 0 && a_dq[0] <= cyc) begin
          a_rdata  = word_of(a_pq.pop_front());
          void'(a_dq.pop_front());
          a_rvalid = 1'b1;
          if (!a_seen_rv) begin a_seen_rv = 1'b1; a_first_rv = cyc; end
        end
        a_ready = a_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (a_req && a_ready) begin
          a_pq.push_back(a_addr);
          a_dq.push_back(cyc + a_lat);
          a_issues++;
          if (!a_seen_iss) begin a_seen_iss = 1'b1; a_first_addr = a_addr; end
        end
      end
    end
  end

  // ---------------- memory model B ----------------
  int unsigned b_lat = 1;
  logic [15:0] b_pq[$];
  int unsigned b_dq[$];
  bit          b_seen_iss = 1'b0;
  logic [15:0] b_first_addr = '0;

  initial begin
    b_ready = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
    forever begin
      @(negedge clock);
      b_rvalid = 1'b0;
      if (b_rst) begin
        b_pq.delete(); b_dq.delete(); b_ready = 1'b0;
      end else begin
        if (b_dq.size() != 0 && b_dq[0] <= cyc) begin
          b_rdata  = word_of({16'h0, b_pq.pop_front()});
          void'(b_dq.pop_front());
          b_rvalid = 1'b1;
        end
        b_ready = 1'b1;
        if (b_req && b_ready) begin
          b_pq.push_back(b_addr);
          b_dq.push_back(cyc + b_lat);
          if (!b_seen_iss) begin b_seen_iss = 1'b1; b_first_addr = b_addr; end
        end
      end
    end
  end

  // ---------------- scoreboards ----------------
  logic [31:0] a_exp[$];
  logic [15:0] b_exp[$];

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (!a_rst && a_valid && a_ins_rdy) begin
        if (a_exp.size() == 0) chk("a_unexpected_pop_pc", a_pc, NONE32);
        else begin
          e = a_exp.pop_front();
          chk("a_pc", a_pc, e);
          chk("a_ins", a_ins, word_of(e));
          chk("a_pcn", a_pcn, e + 32'd4);
        end
      end
    end
  end

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clock);
      if (!b_rst && b_valid && b_ins_rdy) begin
        if (b_exp.size() == 0) chk("b_unexpected_pop_pc", {16'h0, b_pc}, NONE32);
        else begin
          e = b_exp.pop_front();
          chk("b_pc", {16'h0, b_pc}, {16'h0, e});
          chk("b_ins", b_ins, word_of({16'h0, e}));
          chk("b_pcn", {16'h0, b_pcn}, {16'h0, e + 16'd4});
        end
      end
    end
  end

  // Consume A until its expected list is empty; raise redirect on the
  // cycle the head PC equals p1 (target t1) or p2 (target t2).
  task automatic drive_a(input logic [31:0] p1, input logic [31:0] t1,
                         input logic [31:0] p2, input logic [31:0] t2,
                         input int unsigned limit, input string tag);
    int unsigned n = 0;
    a_ins_rdy = 1'b1;
    while (a_exp.size() != 0 && n < limit) begin
      a_redir = a_valid && (a_pc == p1 || a_pc == p2);
      a_rpc   = (a_pc == p1) ? t1 : t2;
      @(posedge clock); #1;
      n++;
    end
    a_ins_rdy = 1'b0;
    a_redir   = 1'b0;
    chk(tag, 32'(a_exp.size()), 32'd0);
  endtask

  bit b_fl_seen = 1'b0;

  task automatic drive_b(input logic [15:0] p1, input logic [15:0] t1,
                         input int unsigned limit, input string tag);
    int unsigned n = 0;
    b_ins_rdy = 1'b1;
    while (b_exp.size() != 0 && n < limit) begin
      if (b_flushing) b_fl_seen = 1'b1;
      b_redir = b_valid && (b_pc == p1);
      b_rpc   = t1;
      @(posedge clock); #1;
      n++;
    end
    b_ins_rdy = 1'b0;
    b_redir   = 1'b0;
    chk(tag, 32'(b_exp.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned rel;
    int unsigned vcyc;
    a_rst = 1'b1; b_rst = 1'b1;
    a_ins_rdy = 1'b0; a_redir = 1'b0; a_rpc = '0;
    b_ins_rdy = 1'b0; b_redir = 1'b0; b_rpc = '0;
    repeat (3) @(posedge clock);
    #1;

    chk("a_rst_req",      32'(a_req),      32'd0);
    chk("a_rst_valid",    32'(a_valid),    32'd0);
    chk("a_rst_ins",      a_ins,           32'd0);
    chk("a_rst_pc",       a_pc,            32'd0);
    chk("a_rst_flushing", 32'(a_flushing), 32'd0);
    chk("b_rst_req",      32'(b_req),      32'd0);
    chk("b_rst_valid",    32'(b_valid),    32'd0);

    // Sequential stream from reset, latency 1, decode always ready
    for (int i = 0; i < 12; i++) a_exp.push_back(32'h0040_0000 + 32'(i * 4));
    a_lat = 1;
    a_rst = 1'b0;
    rel   = cyc;
    a_ins_rdy = 1'b1;
    vcyc  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (a_valid) begin vcyc = cyc; break; end
    end
    chk("t1_release_to_valid", 32'(vcyc - rel), 32'd3);
    chk("t1_rvalid_to_valid",  32'(vcyc - a_first_rv), 32'd1);
    chk("t1_first_addr",       a_first_addr, 32'h0040_0000);
    drive_a(NONE32, '0, NONE32, '0, 200, "t1_drain");

    // Reset asserted mid-cycle with a populated queue and slow fetches in flight
    a_lat = 4;
    repeat (2) @(posedge clock);
    #1;
    chk("t6_pre_valid", 32'(a_valid), 32'd1);
    #2;
    a_rst = 1'b1;
    #1;
    chk("t6_req_now",      32'(a_req),      32'd0);
    chk("t6_valid_now",    32'(a_valid),    32'd0);
    chk("t6_flushing_now", 32'(a_flushing), 32'd0);
    a_seen_iss = 1'b0;
    a_issues   = 0;
    repeat (2) @(posedge clock);
    #1;

    // Decode stalled: credit limit caps requests at the queue depth
    a_lat = 1;
    a_rst = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("t2_issues",     32'(a_issues), 32'd4);
    chk("t2_req_low",    32'(a_req),    32'd0);
    chk("t2_valid",      32'(a_valid),  32'd1);
    chk("t2_first_addr", a_first_addr,  32'h0040_0000);
    for (int i = 0; i < 8; i++) a_exp.push_back(32'h0040_0000 + 32'(i * 4));
    drive_a(NONE32, '0, NONE32, '0, 200, "t2_drain");

    // Delay-slot redirect with slow memory; target low bits must be cleared
    a_rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    a_lat = 5;
    a_rst = 1'b0;
    a_exp.push_back(32'h0040_0000); a_exp.push_back(32'h0040_0004);
    a_exp.push_back(32'h0040_0008); a_exp.push_back(32'h0040_000C);
    a_exp.push_back(32'h0040_0200); a_exp.push_back(32'h0040_0204);
    a_exp.push_back(32'h0040_0208);
    drive_a(32'h0040_0008, 32'h0040_0203, NONE32, '0, 300, "t4_drain");

    // Branch in the delay slot is ignored; first target wins
    a_exp.push_back(32'h0040_020C); a_exp.push_back(32'h0040_0210);
    a_exp.push_back(32'h0040_0214); a_exp.push_back(32'h0040_0300);
    a_exp.push_back(32'h0040_0304);
    drive_a(32'h0040_0210, 32'h0040_0300, 32'h0040_0214, 32'h0040_0500, 300, "t5_drain");

    // Random memory backpressure, stream continues from the redirect target
    a_rnd = 1'b1;
    a_lat = 2;
    for (int i = 0; i < 16; i++) a_exp.push_back(32'h0040_0308 + 32'(i * 4));
    drive_a(NONE32, '0, NONE32, '0, 400, "t7_drain");
    a_rnd = 1'b0;

    // 16-bit, no delay slot: wrap past 0xFFFC then immediate redirect
    b_lat = 3;
    b_exp.push_back(16'hFFF0); b_exp.push_back(16'hFFF4);
    b_exp.push_back(16'hFFF8); b_exp.push_back(16'hFFFC);
    b_exp.push_back(16'h0000); b_exp.push_back(16'h0004);
    b_exp.push_back(16'h0008); b_exp.push_back(16'h0100);
    b_exp.push_back(16'h0104); b_exp.push_back(16'h0108);
    b_rst = 1'b0;
    drive_b(16'h0008, 16'h0102, 300, "t3_drain");
    chk("t3_first_addr",    {16'h0, b_first_addr}, 32'h0000_FFF0);
    chk("t3_flushing_seen", 32'(b_fl_seen),        32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
